// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite grid mover: coordinate sizing,
// move directions, FSM states and the sprite-select decoder.
package sprite_pkg;

    localparam int COORD_W     = 10;
    localparam int NUM_SPRITES = 4;
    localparam int ID_W        = $clog2(NUM_SPRITES);

    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
    typedef enum logic {IDLE, MOVE} state_t;

    // Index of the lowest set select bit; 0 when nothing is selected.
    function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_SPRITES-1:0] s);
        lowest_set = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (s[i]) lowest_set = ID_W'(i);
        end
    endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Registered rising-edge detector for the four direction buttons, followed by
// a fixed-priority pick (up > down > left > right) of a single direction.
module btn_edge_detect
    import sprite_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_i,    // {right, left, down, up}
    output logic       valid_o,
    output logic [1:0] dir_o
);

    logic [3:0] prev_q;
    logic [3:0] edge_q;

    // prev resets high so a button already held at reset release never fires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '1;
            edge_q <= '0;
        end else begin
            edge_q <= btn_i & ~prev_q;
            prev_q <= btn_i;
        end
    end

    always_comb begin
        valid_o = |edge_q;
        dir_o   = DIR_RIGHT;
        if (edge_q[0])      dir_o = DIR_UP;
        else if (edge_q[1]) dir_o = DIR_DOWN;
        else if (edge_q[2]) dir_o = DIR_LEFT;
    end

endmodule

// File: rtl/sprite_grid_mover.sv
// Converts button edges into one-cell glides of the selected sprite, one pixel
// per frame tick, with a single-entry buffer for a request made mid-glide.
module sprite_grid_mover
    import sprite_pkg::*;
#(
    parameter int GRID  = 20,
    parameter int X_MIN = 10,
    parameter int X_MAX = 630,
    parameter int Y_MIN = 10,
    parameter int Y_MAX = 470,
    parameter logic [39:0] INIT_X = {10'd320, 10'd510, 10'd400, 10'd95},
    parameter logic [39:0] INIT_Y = {10'd200, 10'd85, 10'd400, 10'd85}
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic [3:0]  sel,
    input  logic        frame_tick,
    output logic [39:0] pos_x,
    output logic [39:0] pos_y,
    output logic        busy,
    output logic [1:0]  moving_id
);

    localparam int REM_W = $clog2(GRID + 1);

    logic                                  edge_vld;
    logic [1:0]                            edge_dir;
    state_t                                state_q, state_d;
    logic [NUM_SPRITES-1:0][COORD_W-1:0]   px_q, px_d, py_q, py_d;
    logic                                  pend_vld_q, pend_vld_d;
    dir_t                                  pend_dir_q, pend_dir_d, dir_q, dir_d;
    logic [ID_W-1:0]                       pend_id_q, pend_id_d, id_q, id_d;
    logic [REM_W-1:0]                      rem_q, rem_d;
    logic                                  busy_q, busy_d;

    logic            req_vld, src_vld, legal;
    dir_t            src_dir;
    logic [ID_W-1:0] req_id, src_id;
    logic [COORD_W:0] cur_x, cur_y;

    btn_edge_detect u_edge (
        .clk     (clk),
        .reset   (reset),
        .btn_i   ({btn_right, btn_left, btn_down, btn_up}),
        .valid_o (edge_vld),
        .dir_o   (edge_dir)
    );

    // A fresh request takes precedence over the buffered one when launching.
    always_comb begin
        req_vld = edge_vld & (|sel);
        req_id  = lowest_set(sel);
        src_vld = req_vld | pend_vld_q;
        src_dir = req_vld ? dir_t'(edge_dir) : pend_dir_q;
        src_id  = req_vld ? req_id : pend_id_q;
        cur_x   = {1'b0, px_q[src_id]};
        cur_y   = {1'b0, py_q[src_id]};
        legal   = 1'b0;
        case (src_dir)
            DIR_UP:    legal = cur_y >= (COORD_W+1)'(Y_MIN + GRID);
            DIR_DOWN:  legal = cur_y + (COORD_W+1)'(GRID) <= (COORD_W+1)'(Y_MAX);
            DIR_LEFT:  legal = cur_x >= (COORD_W+1)'(X_MIN + GRID);
            DIR_RIGHT: legal = cur_x + (COORD_W+1)'(GRID) <= (COORD_W+1)'(X_MAX);
            default:   legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        px_d       = px_q;
        py_d       = py_q;
        pend_vld_d = pend_vld_q;
        pend_dir_d = pend_dir_q;
        pend_id_d  = pend_id_q;
        dir_d      = dir_q;
        id_d       = id_q;
        rem_d      = rem_q;
        busy_d     = busy_q;
        case (state_q)
            IDLE: begin
                if (src_vld) begin
                    pend_vld_d = 1'b0;
                    if (legal) begin
                        state_d = MOVE;
                        dir_d   = src_dir;
                        id_d    = src_id;
                        rem_d   = REM_W'(GRID);
                        busy_d  = 1'b1;
                    end
                end
            end
            MOVE: begin
                if (req_vld) begin
                    pend_vld_d = 1'b1;
                    pend_dir_d = dir_t'(edge_dir);
                    pend_id_d  = req_id;
                end
                if (frame_tick) begin
                    case (dir_q)
                        DIR_UP:    py_d[id_q] = py_q[id_q] - COORD_W'(1);
                        DIR_DOWN:  py_d[id_q] = py_q[id_q] + COORD_W'(1);
                        DIR_LEFT:  px_d[id_q] = px_q[id_q] - COORD_W'(1);
                        DIR_RIGHT: px_d[id_q] = px_q[id_q] + COORD_W'(1);
                        default:   ;
                    endcase
                    rem_d = rem_q - REM_W'(1);
                    if (rem_q == REM_W'(1)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            px_q       <= INIT_X;
            py_q       <= INIT_Y;
            pend_vld_q <= 1'b0;
            pend_dir_q <= DIR_UP;
            pend_id_q  <= '0;
            dir_q      <= DIR_UP;
            id_q       <= '0;
            rem_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            px_q       <= px_d;
            py_q       <= py_d;
            pend_vld_q <= pend_vld_d;
            pend_dir_q <= pend_dir_d;
            pend_id_q  <= pend_id_d;
            dir_q      <= dir_d;
            id_q       <= id_d;
            rem_q      <= rem_d;
            busy_q     <= busy_d;
        end
    end

    assign pos_x     = px_q;
    assign pos_y     = py_q;
    assign busy      = busy_q;
    assign moving_id = id_q;

endmodule

// File: tb/tb_sprite_grid_mover.sv
// Scoreboard bench for sprite_grid_mover: an event-level model predicts final
// positions of every glide; a monitor checks them when busy falls.
module tb_sprite_grid_mover;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_up, btn_down, btn_left, btn_right;
    logic [3:0]  sel;
    logic        frame_tick;
    logic [39:0] pos_x, pos_y;
    logic        busy;
    logic [1:0]  moving_id;

    sprite_grid_mover dut (
        .clk        (clk),
        .reset      (reset),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .sel        (sel),
        .frame_tick (frame_tick),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .busy       (busy),
        .moving_id  (moving_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [39:0] x;
        logic [39:0] y;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    localparam int IX[4] = '{95, 400, 510, 320};
    localparam int IY[4] = '{85, 400, 85, 200};
    localparam int DX[4] = '{0, 0, -1, 1};   // up, down, left, right
    localparam int DY[4] = '{-1, 1, 0, 0};

    int mx[4], my[4];
    bit m_act, p_vld;
    int m_id, m_dir, m_rem, p_id, p_dir;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [39:0] pack4(input int a[4]);
        logic [39:0] r;
        for (int i = 0; i < 4; i++) r[i*10 +: 10] = 10'(a[i]);
        return r;
    endfunction

    // ---------------- reference model ----------------
    task automatic m_reset();
        mx = IX; my = IY;
        m_act = 0; p_vld = 0; m_rem = 0;
    endtask

    task automatic m_launch(input int id, input int dir);
        int tx[4], ty[4];
        exp_t e;
        tx = mx; ty = my;
        tx[id] += 20 * DX[dir];
        ty[id] += 20 * DY[dir];
        if (tx[id] >= 10 && tx[id] <= 630 && ty[id] >= 10 && ty[id] <= 470) begin
            m_act = 1; m_id = id; m_dir = dir; m_rem = 20;
            e.id = id; e.x = pack4(tx); e.y = pack4(ty);
            sb.push_back(e);
        end
    endtask

    task automatic m_press(input logic [3:0] mask, input logic [3:0] s);
        int dir, id;
        dir = -1; id = -1;
        for (int d = 3; d >= 0; d--) if (mask[d]) dir = d;
        for (int i = 3; i >= 0; i--) if (s[i]) id = i;
        if (dir < 0 || id < 0) return;
        if (m_act) begin
            p_vld = 1; p_id = id; p_dir = dir;
        end else begin
            m_launch(id, dir);
        end
    endtask

    task automatic m_tick();
        if (!m_act) return;
        mx[m_id] += DX[m_dir];
        my[m_id] += DY[m_dir];
        m_rem--;
        if (m_rem == 0) begin
            m_act = 0;
            if (p_vld) begin
                p_vld = 0;
                m_launch(p_id, p_dir);
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string nm);
        chk({nm, ".pos_x"}, 64'(pos_x), 64'(pack4(mx)));
        chk({nm, ".pos_y"}, 64'(pos_y), 64'(pack4(my)));
        chk({nm, ".busy"}, 64'(busy), 64'(m_act));
        if (m_act) chk({nm, ".moving_id"}, 64'(moving_id), 64'(m_id));
    endtask

    task automatic press(input logic [3:0] mask, input logic [3:0] s);
        sel = s;
        {btn_right, btn_left, btn_down, btn_up} = mask;
        step();
        {btn_right, btn_left, btn_down, btn_up} = 4'b0;
        step(); step(); step();
        m_press(mask, s);
        check_all("press");
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step(); step();
            m_tick();
            check_all("tick");
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        bit prev;
        exp_t e;
        prev = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = 0;
            end else begin
                if (prev && !busy) begin
                    if (sb.size() == 0) begin
                        chk("sb_unexpected_done", 64'(1), 64'(0));
                    end else begin
                        e = sb.pop_front();
                        chk("done.pos_x", 64'(pos_x), 64'(e.x));
                        chk("done.pos_y", 64'(pos_y), 64'(e.y));
                    end
                end
                prev = busy;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        reset = 1'b1;
        {btn_right, btn_left, btn_down, btn_up} = 4'b0;
        sel = 4'b0;
        frame_tick = 1'b0;
        m_reset();
        step(); step(); step();
        check_all("reset");
        chk("reset.moving_id", 64'(moving_id), 64'(0));
        reset = 1'b0;
        step();

        // 1: glide and completion of sprite 1 to the right
        press(4'b1000, 4'b0010);
        tick(10);
        chk("t1.x1_mid", 64'(pos_x[19:10]), 64'(410));
        chk("t1.busy_mid", 64'(busy), 64'(1));
        tick(10);
        chk("t1.x1_end", 64'(pos_x[19:10]), 64'(420));
        chk("t1.busy_end", 64'(busy), 64'(0));

        // 2: upper bound on sprite 0
        press(4'b0001, 4'b0001); tick(20);
        chk("t2.y0_a", 64'(pos_y[9:0]), 64'(65));
        press(4'b0001, 4'b0001); tick(20);
        chk("t2.y0_b", 64'(pos_y[9:0]), 64'(45));
        press(4'b0001, 4'b0001); tick(20);
        chk("t2.y0_c", 64'(pos_y[9:0]), 64'(25));
        press(4'b0001, 4'b0001);
        chk("t2.blocked_busy", 64'(busy), 64'(0));
        tick(2);
        chk("t2.y0_d", 64'(pos_y[9:0]), 64'(25));

        // 3: pending buffer, newer request overwrites older
        press(4'b0100, 4'b0100);
        tick(5);
        press(4'b0001, 4'b0100);
        press(4'b0010, 4'b0100);
        tick(15);
        chk("t3.x2", 64'(pos_x[29:20]), 64'(490));
        tick(20);
        chk("t3.y2", 64'(pos_y[29:20]), 64'(105));

        // 4: simultaneous up+left, up wins
        press(4'b0101, 4'b1000);
        tick(20);
        chk("t4.y3", 64'(pos_y[39:30]), 64'(180));
        chk("t4.x3", 64'(pos_x[39:30]), 64'(320));

        // 5: selection, and sel change mid-move
        press(4'b1000, 4'b0110);
        tick(3);
        sel = 4'b0001;
        step();
        tick(17);
        chk("t5.x1", 64'(pos_x[19:10]), 64'(440));
        press(4'b1000, 4'b0000);
        chk("t5.nosel_busy", 64'(busy), 64'(0));

        // 6: reset mid-move, then a button held through reset release
        press(4'b1000, 4'b0010);
        tick(7);
        reset = 1'b1;
        m_reset();
        sb.delete();
        step(); step();
        check_all("t6.reset");
        btn_right = 1'b1;
        step();
        reset = 1'b0;
        step(); step(); step(); step();
        chk("t6.held_busy", 64'(busy), 64'(0));
        btn_right = 1'b0;
        step();
        check_all("t6.after");

        // random phase
        repeat (300) begin
            if ($urandom_range(0, 3) == 0)
                press(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)));
            else
                tick(1);
        end

        // drain any active glide and buffered request
        repeat (45) if (m_act || p_vld) tick(1);
        step();
        chk("sb_empty", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_grid_mover.md
Name: sprite_grid_mover

Overview:
Upstream stage of the VGA sprite renderer. It turns debounced direction buttons and sprite-select switches into one-grid-cell moves. Each rising button edge moves the selected sprite exactly GRID pixels, gliding 1 px per frame tick. It drives the centre coordinates the renderer consumes for its four sprites.

Parameters:
GRID, 20, pixels per move (and frames per move)
X_MIN, 10, smallest legal centre x
X_MAX, 630, largest legal centre x
Y_MIN, 10, smallest legal centre y
Y_MAX, 470, largest legal centre y
INIT_X, {10'd320,10'd510,10'd400,10'd95}, packed reset x for sprites 3..0
INIT_Y, {10'd200,10'd85,10'd400,10'd85}, packed reset y for sprites 3..0

Ports:
clk  in  1  100 MHz system clock
reset  in  1  asynchronous, active-high reset
btn_up  in  1  debounced level, sync to clk
btn_down  in  1  debounced level
btn_left  in  1  debounced level
btn_right  in  1  debounced level
sel  in  4  sprite select switches; lowest set bit wins
frame_tick  in  1  one-clk pulse per frame end
pos_x  out  40  packed centre x, 10 bits per sprite, sprite 0 in [9:0]
pos_y  out  40  packed centre y, 10 bits per sprite
busy  out  1  high while a glide is in progress
moving_id  out  2  sprite being moved (valid when busy)

Interface decided: one clock, clk; reset is asynchronous and active-high, port name reset.

Behaviour:
- Reset values: pos_x=INIT_X, pos_y=INIT_Y, busy=0, moving_id=0, FSM=IDLE, pending cleared, step count 0, btn_prev regs=1. Because btn_prev resets to 1, a button held through reset does not fire.
- Edge detect: edge[d] = btn[d] & ~btn_prev[d], registered every clk.
- Priority for simultaneous edges in one cycle: up > down > left > right. Only one direction is taken; the others are dropped.
- Request: {dir, id} formed from the winning edge. id = lowest set bit of sel. If sel==0, the request is dropped.
- Pending buffer: one entry. A request arriving in MOVE is stored in it. A newer request overwrites the stored one. A request arriving in IDLE is launched directly and never buffered.
- FSM IDLE:
  - The launch source is the new request if present, else the pending entry.
  - Compute target = coord ± GRID.
  - Bounds check uses 11-bit arithmetic:
    - up legal iff y >= Y_MIN+GRID
    - down legal iff y+GRID <= Y_MAX
    - left legal iff x >= X_MIN+GRID
    - right legal iff x+GRID <= X_MAX
  - Legal: latch id and dir, remaining=GRID, busy=1 on the next cycle, go to MOVE.
  - Illegal: drop the request (pending cleared), stay in IDLE.
- FSM MOVE:
  - On each frame_tick, step the latched sprite's coordinate by ±1 and decrement remaining.
  - When the tick brings remaining to 0, go to IDLE; busy=0 on the following cycle.
  - A frame_tick in the same cycle as the launch does not step; the first step is on the next tick.
  - sel changes during MOVE have no effect on the active move.
- Outputs: pos_* registered, updated the cycle after frame_tick. Unmoved sprites never change.
- Latency: button rise sampled at cycle n → edge at n+1 → busy at n+2 → completion after exactly GRID further ticks.
- Reset mid-MOVE: all sprites return to INIT, pending is lost, FSM goes to IDLE.
- No wrap-around possible: the bounds check precedes every launch.

Decomposition:
- Package sprite_pkg holds:
  - COORD_W=10, NUM_SPRITES=4
  - dir_t {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT}
  - state_t {IDLE, MOVE}
  - packed-field index helpers
- Sub-module btn_edge_detect: 4-bit registered rising-edge detector, btn_prev reset to all-ones, plus the priority encoder producing valid+dir.
- Top holds the pending buffer, FSM, bounds check and position registers.

Test Plan:
1. Glide and completion: sel=0010, single btn_right pulse, 20 frame_ticks. After 10 ticks pos_x[19:10]=410 and busy=1. After 20 ticks pos_x[19:10]=420, busy=0, other sprites unchanged.
2. Upper bound: sel=0001, three btn_up presses each run to completion give y0 = 65, 45, 25. A fourth press leaves y0=25 and busy never rises.
3. Pending buffer: sel=0100, btn_left press; during its move press btn_up, then btn_down. After 20 ticks x2=490. The next 20 ticks give y2=105 (down only; up was overwritten).
4. Simultaneous edges: btn_up and btn_left rise in the same cycle, sel=1000. Only y3 moves, 200 → 180; x3 stays 320.
5. Selection: sel=0110 → sprite 1 moves. sel=0000 → no motion, busy=0. Changing sel to 0001 mid-move still completes on the latched sprite.
6. Reset mid-move: assert reset after 7 ticks of a sprite-1 right move. All pos equal INIT, busy=0. A button held through reset release causes no move.
